// File: rtl/vga_hcounter_pkg.sv
// Shared VGA timing constants and region state type for the horizontal and vertical stages.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned H_FRONT_START = H_VISIBLE;
    localparam int unsigned H_SYNC_START  = H_VISIBLE + H_FP;
    localparam int unsigned H_BACK_START  = H_VISIBLE + H_FP + H_SYNC;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } h_state_t;

endpackage

// File: rtl/vga_hcounter_if.sv
// Horizontal timing bus: run enable in, pixel strobe / position / region flags out.
interface vga_hcounter_if;
    logic        en;
    logic        pixTick;
    logic [31:0] hCount;
    logic        lineEnd;
    logic        hSync;
    logic        hActive;

    modport master (
        input  en,
        output pixTick, hCount, lineEnd, hSync, hActive
    );

    modport slave (
        output en,
        input  pixTick, hCount, lineEnd, hSync, hActive
    );
endinterface

// File: rtl/vga_hcounter_pixel_tick_div.sv
// Clock divider producing a one-clk pixel strobe every DIV enabled cycles.
module pixel_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pixTick
);
    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("pixel_tick_div: DIV must be at least 1");
    end

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // rst term keeps the strobe low during reset even when DIV=1 makes the count compare constant
    assign pixTick = en & rst & (div_cnt == LAST);
endmodule

// File: rtl/vga_hcounter.sv
// Horizontal VGA timing: pixel column counter, region FSM, hSync/hActive and line-end strobe.
module vga_hcounter #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    vga_hcounter_if.master bus
);
    import vga_timing_pkg::*;

    localparam logic [31:0] LAST_ACTIVE = 32'(H_VISIBLE - 1);
    localparam logic [31:0] LAST_FRONT  = 32'(H_VISIBLE + H_FP - 1);
    localparam logic [31:0] LAST_SYNC   = 32'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [31:0] LAST_PIXEL  = 32'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);

    if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_region
        $error("vga_hcounter: every horizontal region must be at least one pixel");
    end

    logic        pix_tick;
    logic [31:0] h_count;
    h_state_t    state;
    h_state_t    state_next;

    pixel_tick_div #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .pixTick (pix_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_count <= '0;
        end else if (pix_tick) begin
            h_count <= (h_count == LAST_PIXEL) ? '0 : h_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACTIVE;
        end else begin
            state <= state_next;
        end
    end

    // Region advances on the same tick that moves hCount past each boundary
    always_comb begin
        state_next = state;
        if (pix_tick) begin
            case (state)
                ACTIVE:  if (h_count == LAST_ACTIVE) state_next = FRONT;
                FRONT:   if (h_count == LAST_FRONT)  state_next = SYNC;
                SYNC:    if (h_count == LAST_SYNC)   state_next = BACK;
                BACK:    if (h_count == LAST_PIXEL)  state_next = ACTIVE;
                default: state_next = ACTIVE;
            endcase
        end
    end

    assign bus.pixTick = pix_tick;
    assign bus.hCount  = h_count;
    assign bus.lineEnd = pix_tick & (h_count == LAST_PIXEL);
    assign bus.hActive = (state == ACTIVE);
    assign bus.hSync   = (state == SYNC) ? SYNC_POL : ~SYNC_POL;
endmodule

// File: doc/vga_hcounter.md
# vga_hcounter

Horizontal timing stage of the VGA controller: divides the system clock down to a pixel tick, counts pixels across a line (0..799 for 640x480@60), decodes the horizontal region, and drives the horizontal sync and active-video flag. It sits directly upstream of the vertical counter. Its `lineEnd` output drives the vertical counter's `En` input, so `vCount` advances exactly once per completed line.

## Interface
- `DIV`, 4: system clocks per pixel. Must be ≥1; 100 MHz / 4 = 25 MHz.
- `H_VISIBLE`, 640: active pixels per line.
- `H_FP`, 16: front-porch pixels.
- `H_SYNC`, 96: sync-pulse pixels.
- `H_BP`, 48: back-porch pixels.
- `SYNC_POL`, 0: asserted level of `hSync`.
- `clk`  in  1  system clock. The single clock; every register is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global run enable. When low, all counting freezes.
- `pixTick`  out  1  one-`clk`-wide pixel strobe.
- `hCount`  out  32  current pixel column, 0..H_TOTAL-1.
- `lineEnd`  out  1  one-`clk` pulse on the last pixel of a line. Connects to the vertical counter's `En`.
- `hSync`  out  1  horizontal sync. Equals `SYNC_POL` during the sync region, `~SYNC_POL` otherwise.
- `hActive`  out  1  high while `hCount` is in 0..H_VISIBLE-1.

## Operation
- `H_TOTAL` = H_VISIBLE+H_FP+H_SYNC+H_BP, which is 800 with the defaults.
- **Divider:** `divCnt` counts 0..DIV-1 while `en`=1 and wraps to 0.
  - `pixTick` = `en` & (`divCnt`==DIV-1), decoded from registers.
  - With DIV=1, `pixTick`=`en`.
- **Pixel counter:**
  - `hCount` increments on each clock edge where `pixTick`=1.
  - At H_TOTAL-1 the next tick wraps it to 0.
  - It never exceeds H_TOTAL-1.
- **Region FSM:** states ACTIVE, FRONT, SYNC, BACK. Transitions happen only on `pixTick` edges:
  - ACTIVE→FRONT when `hCount`==H_VISIBLE-1.
  - FRONT→SYNC when `hCount`==H_VISIBLE+H_FP-1.
  - SYNC→BACK when `hCount`==H_VISIBLE+H_FP+H_SYNC-1.
  - BACK→ACTIVE when `hCount`==H_TOTAL-1, together with the wrap.
- **State invariant:** the state always matches `hCount` — ACTIVE 0..639, FRONT 640..655, SYNC 656..751, BACK 752..799.
- **Outputs from state:** `hActive` = (state==ACTIVE). `hSync` = (state==SYNC) ? SYNC_POL : ~SYNC_POL. Both are taken from the state register, so they are glitch-free.
- **Line end:** `lineEnd` = `pixTick` & (`hCount`==H_TOTAL-1).
- **en low:** `divCnt`, `hCount` and state hold; `pixTick`=`lineEnd`=0. Counting resumes from the held values when `en` returns high.
- **Reset (asserted at any time, including mid-line):**
  - `divCnt`=0, `hCount`=0, state=ACTIVE.
  - `pixTick`=0, `lineEnd`=0, `hActive`=1, `hSync`=~SYNC_POL.

## Timing
- Latency `pixTick`→`hCount` update: 1 `clk`.
- `hSync` and `hActive` change on the same edge as `hCount`.
- `lineEnd` is high in the same cycle that `hCount`==H_TOTAL-1 and `pixTick`=1. On that edge:
  - `hCount` wraps to 0;
  - the downstream `vCount` increments on the same edge.
- Line period: H_TOTAL·DIV `clk` cycles, i.e. 3200 at defaults.
- `hSync` asserted width: H_SYNC·DIV = 384 `clk`.
- Reset release: the first `pixTick` arrives DIV `clk` edges after deassertion, provided `en`=1.
- Reset deassertion is synchronous in effect: the design assumes `rst` is released away from the `clk` edge.

## Structure
- **Package `vga_timing_pkg`:**
  - constants: H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL, plus the region boundary values;
  - the region state enum `h_state_t`;
  - the vertical counter's constants, so both stages share one source.
- **Sub-module `pixel_tick_div`:** holds `divCnt` and produces `pixTick`, with ports `clk`, `rst`, `en`, `pixTick` and parameter DIV. The vertical path reuses it.
- Parameters must satisfy each of H_VISIBLE, H_FP, H_SYNC, H_BP ≥1. An elaboration-time check enforces this.

## Test plan
- **Reset:** assert `rst`=0 mid-SYNC at `hCount`=700 → immediately `hCount`=0, `hSync`=1, `hActive`=1, `pixTick`=0. After release, first `pixTick` at clk edge 4.
- **Free run, defaults:** `pixTick` every 4 `clk`; `hCount` reaches 799 and then 0. `lineEnd` pulses once per 3200 `clk`, exactly 1 cycle wide, coincident with `hCount`=799.
- **Sync window:** `hSync`=0 exactly while `hCount`∈656..751, i.e. 384 `clk`. `hActive`=1 exactly for `hCount`∈0..639. No glitches on either.
- **Enable gating:** drop `en` for 37 `clk` at `hCount`=799 with `divCnt`=2 → no `lineEnd` and no change. After `en`=1, `lineEnd` fires after 1 `clk`.
- **Downstream link:** connect to the vertical counter. After 525·3200 `clk`, `vCount` has cycled 0→524→0, with one increment per `lineEnd`.
- **DIV=1, SYNC_POL=1:** `pixTick` is constant high. Line = 800 `clk`; `hSync`=1 for 96 `clk`.
